de_stage: RTL and testbench

DE_STAGE -- requirements
Module: de_stage

---
 rtl/de_stage_if.sv | 34 +++
 rtl/de_stage.sv | 145 ++++++++++++++
 tb/tb_de_stage.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/de_stage_if.sv
// Decode-stage bus: fetch latch in, writeback and flush in, DE latch and stall out.
// The stage itself is the slave; whatever drives fetch/writeback is the master.
interface de_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            fe_valid;
  logic [31:0]     fe_inst;
  logic [XLEN-1:0] fe_pc;
  logic            agex_flush;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            de_stall;
  logic            out_valid;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [4:0]      out_rd;
  logic            out_wr_reg;

  modport slave (
    input  fe_valid, fe_inst, fe_pc, agex_flush, wb_we, wb_rd, wb_data,
    output de_stall, out_valid, out_inst, out_pc, out_imm, out_rs1_val, out_rs2_val,
           out_rd, out_wr_reg
  );

  modport master (
    output fe_valid, fe_inst, fe_pc, agex_flush, wb_we, wb_rd, wb_data,
    input  de_stall, out_valid, out_inst, out_pc, out_imm, out_rs1_val, out_rs2_val,
           out_rd, out_wr_reg
  );
endinterface

// File: rtl/de_stage.sv
// RV32I decode stage: register file, immediate decode, scoreboard of in-flight
// writes per register, RAW stall generation and the DE pipeline latch.
module de_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned SB_BITS = 3
) (
  input logic         clk,
  input logic         reset,
  de_stage_if.slave   bus
);
  localparam int unsigned IdxW = $clog2(NREGS);
  typedef logic [IdxW-1:0] idx_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [SB_BITS-1:0] CntOne = SB_BITS'(1);

  logic [XLEN-1:0]    rf_q  [NREGS];
  logic [SB_BITS-1:0] cnt_q [NREGS];
  logic [SB_BITS-1:0] cnt_d [NREGS];

  logic            out_valid_q, out_wr_reg_q;
  logic [31:0]     out_inst_q;
  logic [XLEN-1:0] out_pc_q, out_imm_q, out_rs1_val_q, out_rs2_val_q;
  logic [4:0]      out_rd_q;

  logic [6:0]        opcode;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm;
  logic              use_rs1, use_rs2, writes_rd, wr_reg;
  idx_t              rs1, rs2, rd, wb_idx, flush_idx;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic              wb_hit1, wb_hit2, busy1, busy2;
  logic              stall, issue, flush_undo;

  assign opcode    = bus.fe_inst[6:0];
  assign rs1       = idx_t'(bus.fe_inst[19:15]);
  assign rs2       = idx_t'(bus.fe_inst[24:20]);
  assign rd        = idx_t'(bus.fe_inst[11:7]);
  assign wb_idx    = idx_t'(bus.wb_rd);
  assign flush_idx = idx_t'(out_rd_q);

  always_comb begin
    imm32 = '0;
    case (opcode)
      OpLoad, OpImm, OpJalr: imm32 = {{20{bus.fe_inst[31]}}, bus.fe_inst[31:20]};
      OpStore:  imm32 = {{20{bus.fe_inst[31]}}, bus.fe_inst[31:25], bus.fe_inst[11:7]};
      OpBranch: imm32 = {{19{bus.fe_inst[31]}}, bus.fe_inst[31], bus.fe_inst[7],
                         bus.fe_inst[30:25], bus.fe_inst[11:8], 1'b0};
      OpLui, OpAuipc: imm32 = {bus.fe_inst[31:12], 12'b0};
      OpJal:    imm32 = {{11{bus.fe_inst[31]}}, bus.fe_inst[31], bus.fe_inst[19:12],
                         bus.fe_inst[20], bus.fe_inst[30:21], 1'b0};
      default:  imm32 = '0;
    endcase
  end

  assign imm       = XLEN'(imm32);
  assign use_rs1   = !(opcode inside {OpLui, OpAuipc, OpJal});
  assign use_rs2   = opcode inside {OpOp, OpStore, OpBranch};
  assign writes_rd = opcode inside {OpOp, OpImm, OpLoad, OpLui, OpAuipc, OpJal, OpJalr};
  assign wr_reg    = writes_rd && (bus.fe_inst[11:7] != 5'd0);

  // A writeback landing this cycle satisfies one outstanding write (write-through read).
  assign wb_hit1 = bus.wb_we && (wb_idx == rs1) && (rs1 != '0);
  assign wb_hit2 = bus.wb_we && (wb_idx == rs2) && (rs2 != '0);

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = wb_hit1 ? bus.wb_data : rf_q[rs1];
    if (rs2 != '0) rs2_val = wb_hit2 ? bus.wb_data : rf_q[rs2];
  end

  assign busy1 = (cnt_q[rs1] > CntOne) || ((cnt_q[rs1] == CntOne) && !wb_hit1);
  assign busy2 = (cnt_q[rs2] > CntOne) || ((cnt_q[rs2] == CntOne) && !wb_hit2);

  assign stall = !reset && bus.fe_valid && !bus.agex_flush &&
                 ((use_rs1 && busy1) || (use_rs2 && busy2));
  assign issue = !reset && bus.fe_valid && !stall && !bus.agex_flush;
  assign flush_undo = bus.agex_flush && out_valid_q && out_wr_reg_q;

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (issue && wr_reg && (rd == idx_t'(i))) cnt_d[i] = cnt_d[i] + CntOne;
      if (bus.wb_we && (wb_idx == idx_t'(i)))   cnt_d[i] = cnt_d[i] - CntOne;
      if (flush_undo && (flush_idx == idx_t'(i))) cnt_d[i] = cnt_d[i] - CntOne;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Register file has no reset; x0 is never written and reads are forced to 0.
  always_ff @(posedge clk) begin
    if (!reset && bus.wb_we && (wb_idx != '0)) rf_q[wb_idx] <= bus.wb_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_wr_reg_q  <= 1'b0;
      out_inst_q    <= '0;
      out_pc_q      <= '0;
      out_imm_q     <= '0;
      out_rs1_val_q <= '0;
      out_rs2_val_q <= '0;
      out_rd_q      <= '0;
    end else begin
      out_valid_q   <= issue;
      out_wr_reg_q  <= issue && wr_reg;
      out_inst_q    <= bus.fe_inst;
      out_pc_q      <= bus.fe_pc;
      out_imm_q     <= imm;
      out_rs1_val_q <= rs1_val;
      out_rs2_val_q <= rs2_val;
      out_rd_q      <= bus.fe_inst[11:7];
    end
  end

  assign bus.de_stall    = stall;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_wr_reg  = out_wr_reg_q;
  assign bus.out_inst    = out_inst_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_rs1_val = out_rs1_val_q;
  assign bus.out_rs2_val = out_rs2_val_q;
  assign bus.out_rd      = out_rd_q;
endmodule

// File: tb/tb_de_stage.sv
// Bench for de_stage: a behavioural pipeline/scoreboard model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_de_stage;
  localparam int XLEN = 32, NREGS = 32, SB_BITS = 3, CMAX = 7;

  localparam logic [6:0] OP_LOAD = 7'h03, OP_IMM = 7'h13, OP_AUIPC = 7'h17, OP_STORE = 7'h23;
  localparam logic [6:0] OP_OP = 7'h33, OP_LUI = 7'h37, OP_BRANCH = 7'h63, OP_JALR = 7'h67;
  localparam logic [6:0] OP_JAL = 7'h6f;

  localparam logic [31:0] ADDI_X5_7  = 32'h0070_0293;
  localparam logic [31:0] ADD_X6_X5  = 32'h0052_8333;
  localparam logic [31:0] ADDI_X3_1  = 32'h0010_0193;
  localparam logic [31:0] SUB_X4     = 32'h4020_8233;
  localparam logic [31:0] ADDI_X9_1  = 32'h0010_0493;
  localparam logic [31:0] ADDI_X9_2  = 32'h0020_0493;
  localparam logic [31:0] BEQ_M4     = 32'hFE00_0EE3;
  localparam logic [31:0] ADD_X10_0  = 32'h0000_0533;
  localparam logic [31:0] ADD_X11_0  = 32'h0000_05B3;
  localparam logic [31:0] LUI_X12    = 32'h1234_5637;
  localparam logic [31:0] SW_X5_8    = 32'h0051_2423;
  localparam logic [31:0] JAL_X1_16  = 32'h0100_00EF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  de_stage_if #(.XLEN(XLEN)) bus ();

  de_stage #(.XLEN(XLEN), .NREGS(NREGS), .SB_BITS(SB_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [NREGS];
  bit          m_known [NREGS];
  int          m_cnt [NREGS];
  bit          m_live = 0;
  bit          m_valid, m_wr, m_rs1k, m_rs2k;
  logic [31:0] m_inst, m_pc, m_imm, m_rs1v, m_rs2v;
  int          m_rd;

  function automatic logic [31:0] m_imm_of(input logic [31:0] ins);
    int s;
    s = int'(ins);
    case (ins[6:0])
      OP_LOAD, OP_IMM, OP_JALR: return 32'(s >>> 20);
      OP_STORE:  return 32'(((s >>> 25) <<< 5) + int'(ins[11:7]));
      OP_BRANCH: return 32'(((s >>> 31) <<< 12) + int'(ins[7]) * 2048 +
                            int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
      OP_LUI, OP_AUIPC: return ins & 32'hFFFF_F000;
      OP_JAL:    return 32'(((s >>> 31) <<< 20) + int'(ins[19:12]) * 4096 +
                            int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
      default:   return 32'h0;
    endcase
  endfunction

  function automatic bit m_reads1(input logic [31:0] ins);
    return !(ins[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic bit m_reads2(input logic [31:0] ins);
    return ins[6:0] inside {OP_OP, OP_STORE, OP_BRANCH};
  endfunction

  function automatic bit m_writes(input logic [31:0] ins);
    return (ins[6:0] inside {OP_OP, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR}) &&
           (ins[11:7] != 5'd0);
  endfunction

  // Outstanding writes to rs that this cycle's writeback does not retire.
  function automatic int m_pending(input int rs);
    if (rs == 0) return 0;
    return m_cnt[rs] - ((bus.wb_we && int'(bus.wb_rd) == rs) ? 1 : 0);
  endfunction

  function automatic bit m_stall();
    logic [31:0] ins;
    ins = bus.fe_inst;
    if (reset || !bus.fe_valid || bus.agex_flush) return 1'b0;
    return (m_reads1(ins) && m_pending(int'(ins[19:15])) > 0) ||
           (m_reads2(ins) && m_pending(int'(ins[24:20])) > 0);
  endfunction

  function automatic logic [32:0] m_operand(input int rs);
    if (rs == 0) return {1'b1, 32'h0};
    if (bus.wb_we && int'(bus.wb_rd) == rs) return {1'b1, bus.wb_data};
    return {m_known[rs], m_rf[rs]};
  endfunction

  always @(posedge clk) begin : model
    logic [32:0] o1, o2;
    logic [31:0] ins;
    bit          iss;
    if (reset) begin
      for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
      m_valid = 0; m_wr = 0; m_inst = 0; m_pc = 0; m_imm = 0; m_rs1v = 0; m_rs2v = 0;
      m_rd = 0; m_rs1k = 1; m_rs2k = 1; m_live = 1;
    end else begin
      ins = bus.fe_inst;
      iss = bus.fe_valid && !m_stall() && !bus.agex_flush;
      o1  = m_operand(int'(ins[19:15]));
      o2  = m_operand(int'(ins[24:20]));
      if (bus.agex_flush && m_valid && m_wr) m_cnt[m_rd]--;
      if (bus.wb_we && bus.wb_rd != 5'd0) begin
        m_cnt[bus.wb_rd]--;
        m_rf[bus.wb_rd]    = bus.wb_data;
        m_known[bus.wb_rd] = 1;
      end
      m_valid = iss;
      m_wr    = iss && m_writes(ins);
      if (iss) begin
        m_inst = ins; m_pc = bus.fe_pc; m_imm = m_imm_of(ins); m_rd = int'(ins[11:7]);
        m_rs1v = o1[31:0]; m_rs1k = o1[32]; m_rs2v = o2[31:0]; m_rs2k = o2[32];
        if (m_wr) m_cnt[m_rd]++;
      end
    end
    for (int i = 0; i < NREGS; i++)
      assert (m_cnt[i] >= 0 && m_cnt[i] <= CMAX)
        else $error("scoreboard counter %0d out of range: %0d", i, m_cnt[i]);
  end

  // One compare per cycle, away from the active edge.
  always @(negedge clk) begin : compare
    logic [NREGS*SB_BITS-1:0] dv, mv;
    if (m_live) begin
      check("de_stall", 64'(bus.de_stall), 64'(m_stall()));
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("out_wr_reg", 64'(bus.out_wr_reg), 64'(m_wr));
      if (m_valid) begin
        check("out_inst", 64'(bus.out_inst), 64'(m_inst));
        check("out_pc", 64'(bus.out_pc), 64'(m_pc));
        check("out_imm", 64'(bus.out_imm), 64'(m_imm));
        check("out_rd", 64'(bus.out_rd), 64'(m_rd));
        if (m_rs1k) check("out_rs1_val", 64'(bus.out_rs1_val), 64'(m_rs1v));
        if (m_rs2k) check("out_rs2_val", 64'(bus.out_rs2_val), 64'(m_rs2v));
      end
      for (int i = 0; i < NREGS; i++) begin
        dv[i*SB_BITS +: SB_BITS] = dut.cnt_q[i];
        mv[i*SB_BITS +: SB_BITS] = SB_BITS'(m_cnt[i]);
      end
      check("counters", 64'(dv[63:0]), 64'(mv[63:0]));
      check("counters_hi", 64'(dv[NREGS*SB_BITS-1:64]), 64'(mv[NREGS*SB_BITS-1:64]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit fv, input logic [31:0] inst, input logic [31:0] pc,
                       input bit flush, input bit we, input logic [4:0] rd,
                       input logic [31:0] data);
    bus.fe_valid = fv; bus.fe_inst = inst; bus.fe_pc = pc; bus.agex_flush = flush;
    bus.wb_we = we; bus.wb_rd = rd; bus.wb_data = data;
  endtask

  task automatic idle();
    drive(0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_sum();
    int s;
    s = 0;
    for (int i = 0; i < NREGS; i++) s += int'(dut.cnt_q[i]);
    return s;
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_pc", 64'(bus.out_pc), 64'h0);
    check("rst_out_imm", 64'(bus.out_imm), 64'h0);
    check("rst_cnt_sum", 64'(cnt_sum()), 64'h0);
    reset = 1'b0;

    // ADDI x5,x0,7 at 0x100
    drive(1, ADDI_X5_7, 32'h100, 0, 0, 5'd0, 32'h0);
    tick();
    check("addi_valid", 64'(bus.out_valid), 64'h1);
    check("addi_pc", 64'(bus.out_pc), 64'h100);
    check("addi_imm", 64'(bus.out_imm), 64'h7);
    check("addi_rd", 64'(bus.out_rd), 64'h5);
    check("addi_wr", 64'(bus.out_wr_reg), 64'h1);
    check("addi_cnt5", 64'(dut.cnt_q[5]), 64'h1);

    // ADD x6,x5,x5 stalls on x5, then issues with the bypassed writeback
    drive(1, ADD_X6_X5, 32'h104, 0, 0, 5'd0, 32'h0);
    #1 check("raw_stall", 64'(bus.de_stall), 64'h1);
    tick();
    check("raw_bubble", 64'(bus.out_valid), 64'h0);
    drive(1, ADD_X6_X5, 32'h104, 0, 1, 5'd5, 32'h7);
    #1 check("raw_release", 64'(bus.de_stall), 64'h0);
    tick();
    check("byp_rs1", 64'(bus.out_rs1_val), 64'h7);
    check("byp_rs2", 64'(bus.out_rs2_val), 64'h7);
    check("byp_cnt5", 64'(dut.cnt_q[5]), 64'h0);
    check("byp_cnt6", 64'(dut.cnt_q[6]), 64'h1);

    // ADDI x3 in DE, flush while SUB x4 waits in FE
    drive(1, ADDI_X3_1, 32'h108, 0, 0, 5'd0, 32'h0);
    tick();
    check("x3_cnt", 64'(dut.cnt_q[3]), 64'h1);
    drive(1, SUB_X4, 32'h10c, 1, 0, 5'd0, 32'h0);
    #1 check("flush_nostall", 64'(bus.de_stall), 64'h0);
    tick();
    check("flush_valid", 64'(bus.out_valid), 64'h0);
    check("flush_cnt3", 64'(dut.cnt_q[3]), 64'h0);
    check("flush_cnt4", 64'(dut.cnt_q[4]), 64'h0);
    drive(0, 32'h0, 32'h0, 0, 1, 5'd6, 32'h66);
    tick();

    // Issue to x9 in the same cycle as a writeback of x9
    drive(1, ADDI_X9_1, 32'h110, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, ADDI_X9_2, 32'h114, 0, 1, 5'd9, 32'h99);
    tick();
    check("x9_net_zero", 64'(dut.cnt_q[9]), 64'h1);
    drive(0, 32'h0, 32'h0, 0, 1, 5'd9, 32'h2);
    tick();

    // Branch immediate, and x0 ignoring a write
    drive(1, BEQ_M4, 32'h118, 0, 0, 5'd0, 32'h0);
    tick();
    check("beq_imm", 64'(bus.out_imm), 64'hFFFF_FFFC);
    check("beq_wr", 64'(bus.out_wr_reg), 64'h0);
    drive(1, ADD_X10_0, 32'h11c, 0, 1, 5'd0, 32'hDEAD);
    tick();
    check("x0_nobypass", 64'(bus.out_rs1_val), 64'h0);
    drive(1, ADD_X11_0, 32'h120, 0, 1, 5'd10, 32'h1010);
    tick();
    check("x0_read", 64'(bus.out_rs2_val), 64'h0);
    drive(1, LUI_X12, 32'h124, 0, 1, 5'd11, 32'h1111);
    tick();
    check("lui_imm", 64'(bus.out_imm), 64'h1234_5000);
    drive(1, SW_X5_8, 32'h128, 0, 1, 5'd12, 32'h1212);
    tick();
    check("sw_imm", 64'(bus.out_imm), 64'h8);
    check("sw_rs2", 64'(bus.out_rs2_val), 64'h7);
    drive(1, JAL_X1_16, 32'h12c, 0, 0, 5'd0, 32'h0);
    tick();
    check("jal_imm", 64'(bus.out_imm), 64'h10);
    drive(0, 32'h0, 32'h0, 0, 1, 5'd1, 32'h130);
    tick();

    // Reset in the middle of a stall
    drive(1, ADDI_X5_7, 32'h200, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, ADD_X6_X5, 32'h204, 0, 0, 5'd0, 32'h0);
    #1 check("pre_rst_stall", 64'(bus.de_stall), 64'h1);
    tick();
    reset = 1'b1;
    #1 check("rst_nostall", 64'(bus.de_stall), 64'h0);
    tick();
    check("rst2_cnt_sum", 64'(cnt_sum()), 64'h0);
    check("rst2_valid", 64'(bus.out_valid), 64'h0);
    check("rst2_stall", 64'(bus.de_stall), 64'h0);
    reset = 1'b0;
    #1 check("post_rst_stall", 64'(bus.de_stall), 64'h0);
    tick();
    check("rf_kept", 64'(bus.out_rs1_val), 64'h7);
    drive(0, 32'h0, 32'h0, 0, 1, 5'd6, 32'h0);
    tick();
    idle();
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
